// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: states, opcode constants and datapath select encodings for the multi-cycle control unit.
// Revision 1.0
`default_nettype none

package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6,
    S_TRAP      = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE  = 4'd0,
    CLS_R     = 4'd1,
    CLS_IALU  = 4'd2,
    CLS_LOAD  = 4'd3,
    CLS_STORE = 4'd4,
    CLS_BRANCH= 4'd5,
    CLS_JAL   = 4'd6,
    CLS_JALR  = 4'd7,
    CLS_LUI   = 4'd8,
    CLS_AUIPC = 4'd9
  } opclass_t;

  localparam logic [4:0] OPC_R      = 5'b01100;
  localparam logic [4:0] OPC_IALU   = 5'b00100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;
  localparam logic [4:0] OPC_FENCE  = 5'b00011;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BCMP = 2'b01;
  localparam logic [1:0] ALU_RFN  = 2'b10;
  localparam logic [1:0] ALU_IFN  = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_ALU    = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  localparam logic [1:0] SRCA_RS1    = 2'b00;
  localparam logic [1:0] SRCA_PC_OLD = 2'b01;
  localparam logic [1:0] SRCA_ZERO   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  // Only opcodes that proceed to EXECUTE get a class; SYSTEM/FENCE/illegal map to CLS_NONE.
  function automatic opclass_t classify(input logic [4:0] opc);
    case (opc)
      OPC_R:      return CLS_R;
      OPC_IALU:   return CLS_IALU;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_JALR:   return CLS_JALR;
      OPC_LUI:    return CLS_LUI;
      OPC_AUIPC:  return CLS_AUIPC;
      default:    return CLS_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: unified memory port handshake between control unit and memory.
// Revision 1.0
`default_nettype none

interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic mem_addr_sel;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_addr_sel, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_addr_sel, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive unanswered request cycles and flags expiry at TIMEOUT_CYCLES.
// Revision 1.0
`default_nettype none

module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  active,
  input  wire  ready,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Held at zero outside request states, so every FETCH/MEM entry starts from zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!active || ready) begin
      count <= '0;
    end else if (count != CNT_LAST) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = active && !ready && (count == CNT_LAST);

endmodule

`default_nettype wire

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multi-cycle sequencing FSM with bounded memory waits and sticky HALT/TRAP.
// Optional RETIRE_COUNT_EN adds retire/instret outputs. Revision 1.0
`default_nettype none

module multicycle_control_unit
  import rv_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire  [31:0] inst,
  multicycle_control_unit_if.master bus,
  output logic        ir_write,
  output logic        pc_write,
  output logic        branch,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic        alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        illegal_inst,
  output logic        bus_error
`ifdef RETIRE_COUNT_EN
  ,
  output logic        retire,
  output logic [31:0] instret
`endif
);

  state_t   state, state_nx;
  opclass_t opclass, dec_class;
  logic     mem_req, mem_we, mem_addr_sel;
  logic     timer_active, timer_expired;
  logic     set_halt, set_illegal, set_bus_err, retire_now;
  logic     unused_inst_bits;

  assign unused_inst_bits = ^{inst[31:15], inst[11:7]};
  assign dec_class        = (inst[1:0] == 2'b11) ? classify(inst[6:2]) : CLS_NONE;
  assign timer_active     = (state == S_FETCH) || (state == S_MEM);

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .active  (timer_active),
    .ready   (bus.mem_ready),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      opclass      <= CLS_NONE;
      halted       <= 1'b0;
      illegal_inst <= 1'b0;
      bus_error    <= 1'b0;
    end else begin
      state        <= state_nx;
      if (state == S_DECODE) opclass <= dec_class;
      halted       <= halted | set_halt;
      illegal_inst <= illegal_inst | set_illegal;
      bus_error    <= bus_error | set_bus_err;
    end
  end

  always_comb begin
    state_nx     = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    branch       = 1'b0;
    pc_src       = PC_PLUS4;
    alu_src_a    = SRCA_RS1;
    alu_src_b    = 1'b0;
    alu_op       = ALU_ADD;
    reg_write    = 1'b0;
    wb_sel       = WB_ALU;
    set_halt     = 1'b0;
    set_illegal  = 1'b0;
    set_bus_err  = 1'b0;
    retire_now   = 1'b0;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_PLUS4;
          state_nx = S_DECODE;
        end else if (timer_expired) begin
          set_bus_err = 1'b1;
          state_nx    = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_class != CLS_NONE) begin
          state_nx = S_EXECUTE;
        end else if (inst[1:0] == 2'b11 && inst[6:2] == OPC_SYSTEM && inst[14:12] == 3'b000) begin
          set_halt = 1'b1;
          state_nx = S_HALT;
        end else if (inst[1:0] == 2'b11 && inst[6:2] == OPC_FENCE) begin
          retire_now = 1'b1;
          state_nx   = S_FETCH;
        end else begin
          set_illegal = 1'b1;
          state_nx    = S_TRAP;
        end
      end
      S_EXECUTE: begin
        state_nx = S_WRITEBACK;
        case (opclass)
          CLS_R:    alu_op = ALU_RFN;
          CLS_IALU: begin alu_op = ALU_IFN; alu_src_b = 1'b1; end
          CLS_LOAD, CLS_STORE: begin
            alu_op    = ALU_ADD;
            alu_src_b = 1'b1;
            state_nx  = S_MEM;
          end
          CLS_BRANCH: begin
            alu_op     = ALU_BCMP;
            branch     = 1'b1;
            pc_src     = PC_BRANCH;
            retire_now = 1'b1;
            state_nx   = S_FETCH;
          end
          CLS_JAL, CLS_JALR: begin
            alu_src_a = (opclass == CLS_JAL) ? SRCA_PC_OLD : SRCA_RS1;
            alu_src_b = 1'b1;
            pc_write  = 1'b1;
            pc_src    = PC_ALU;
          end
          CLS_LUI:   begin alu_src_a = SRCA_ZERO;   alu_src_b = 1'b1; end
          CLS_AUIPC: begin alu_src_a = SRCA_PC_OLD; alu_src_b = 1'b1; end
          default: begin
            set_illegal = 1'b1;
            state_nx    = S_TRAP;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opclass == CLS_STORE);
        if (bus.mem_ready) begin
          retire_now = (opclass == CLS_STORE);
          state_nx   = (opclass == CLS_STORE) ? S_FETCH : S_WRITEBACK;
        end else if (timer_expired) begin
          set_bus_err = 1'b1;
          state_nx    = S_TRAP;
        end
      end
      S_WRITEBACK: begin
        reg_write  = 1'b1;
        retire_now = 1'b1;
        if (opclass == CLS_LOAD) wb_sel = WB_MEM;
        else if (opclass == CLS_JAL || opclass == CLS_JALR) wb_sel = WB_PC4;
        else wb_sel = WB_ALU;
        state_nx = S_FETCH;
      end
      default: state_nx = state;
    endcase
  end

  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.mem_addr_sel = mem_addr_sel;

`ifdef RETIRE_COUNT_EN
  assign retire = retire_now;

  always_ff @(posedge clk) begin
    if (!rst_n) instret <= 32'd0;
    else if (retire_now) instret <= instret + 32'd1;
  end
`else
  logic unused_retire;
  assign unused_retire = retire_now;
`endif

endmodule

`default_nettype wire
